// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types and the branch-predictor controller states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

endpackage

// File: rtl/gshare_predictor_if.sv
// ID-stage predict port and WB-stage training port of the gshare predictor.
// master = pipeline side, slave = predictor side.
interface gshare_predictor_if
  import lc3b_types::*;
#(
  parameter int hist_width = 4
) ();

  logic                  predict_valid;
  lc3b_word              PC_id;
  logic                  predict_taken;
  logic [hist_width-1:0] branch_hist_id;
  logic                  ready;

  logic                  update_valid;
  lc3b_word              PC_wb;
  logic [hist_width-1:0] hist_wb;
  logic                  taken_wb;
  logic                  mispredict_wb;

  modport master (
    output predict_valid, PC_id,
    output update_valid, PC_wb, hist_wb, taken_wb, mispredict_wb,
    input  predict_taken, branch_hist_id, ready
  );

  modport slave (
    input  predict_valid, PC_id,
    input  update_valid, PC_wb, hist_wb, taken_wb, mispredict_wb,
    output predict_taken, branch_hist_id, ready
  );

endinterface

// File: rtl/gshare_predictor_counter_table.sv
// Saturating-counter storage: two async read ports (predict, train), one write port.
// Zero-latency reads; a write lands at the clock edge, so same-cycle reads see the old value.
module bp_counter_table #(
  parameter int ctr_width  = 2,
  parameter int index_bits = 5
) (
  input  logic                  clk,
  input  logic [index_bits-1:0] rd_a_idx,
  output logic [ctr_width-1:0]  rd_a_dat,
  input  logic [index_bits-1:0] rd_b_idx,
  output logic [ctr_width-1:0]  rd_b_dat,
  input  logic                  wr_vld,
  input  logic [index_bits-1:0] wr_idx,
  input  logic [ctr_width-1:0]  wr_dat
);

  localparam int depth = 1 << index_bits;

  // No reset here: the controller's init sweep owns table contents.
  logic [ctr_width-1:0] ctr_q [depth];

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      ctr_q[wr_idx] <= wr_dat;
    end
  end

  assign rd_a_dat = ctr_q[rd_a_idx];
  assign rd_b_dat = ctr_q[rd_b_idx];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: combinational predict in ID, train/restore from WB.
// Stalls nothing itself; ready stays low for 2^index_bits cycles after reset while the table is swept.
module gshare_predictor
  import lc3b_types::*;
#(
  parameter int hist_width = 4,  // 1 <= hist_width <= index_bits
  parameter int index_bits = 5,  // at most 14: PC bit 0 is always zero
  parameter int ctr_width  = 2   // >= 2
) (
  input  logic             clk,
  input  logic             reset,
  gshare_predictor_if.slave bp
);

  localparam int depth = 1 << index_bits;
  localparam logic [ctr_width-1:0]  ctr_max  = '1;
  localparam logic [index_bits-1:0] last_idx = index_bits'(depth - 1);

  function automatic logic [ctr_width-1:0] weak_not_taken();
    return ctr_width'((1 << (ctr_width - 1)) - 1);
  endfunction

  // History folds into the upper index bits; low PC bits pass through untouched.
  function automatic logic [index_bits-1:0] bp_index(
    input logic [index_bits-1:0] base,
    input logic [hist_width-1:0] h
  );
    return base ^ (index_bits'(h) << (index_bits - hist_width));
  endfunction

  // Newest outcome enters at the LSB; with hist_width=1 this is just the new bit.
  function automatic logic [hist_width-1:0] shift_in(
    input logic [hist_width-1:0] h,
    input logic                  b
  );
    return hist_width'({h, b});
  endfunction

  bp_state_t             state_q, state_nxt;
  logic [index_bits-1:0] init_idx_q, init_idx_nxt;
  logic [hist_width-1:0] hist_q, hist_nxt;

  logic                  ready;
  logic                  pred_taken;
  logic [index_bits-1:0] pred_idx;
  logic [index_bits-1:0] upd_idx;
  logic [ctr_width-1:0]  pred_ctr;
  logic [ctr_width-1:0]  upd_ctr;
  logic [ctr_width-1:0]  upd_ctr_nxt;

  logic                  wr_vld;
  logic [index_bits-1:0] wr_idx;
  logic [ctr_width-1:0]  wr_dat;

  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{bp.PC_id[15:index_bits+1], bp.PC_id[0],
                            bp.PC_wb[15:index_bits+1], bp.PC_wb[0]};

  assign ready    = (state_q == BP_RUN);
  assign pred_idx = bp_index(bp.PC_id[index_bits:1], hist_q);
  assign upd_idx  = bp_index(bp.PC_wb[index_bits:1], bp.hist_wb);

  assign pred_taken        = pred_ctr[ctr_width-1] & ready;
  assign bp.predict_taken  = pred_taken;
  assign bp.branch_hist_id = hist_q;
  assign bp.ready          = ready;

  bp_counter_table #(
    .ctr_width  (ctr_width),
    .index_bits (index_bits)
  ) u_table (
    .clk      (clk),
    .rd_a_idx (pred_idx),
    .rd_a_dat (pred_ctr),
    .rd_b_idx (upd_idx),
    .rd_b_dat (upd_ctr),
    .wr_vld   (wr_vld),
    .wr_idx   (wr_idx),
    .wr_dat   (wr_dat)
  );

  always_comb begin
    upd_ctr_nxt = upd_ctr;
    if (bp.taken_wb) begin
      if (upd_ctr != ctr_max) begin
        upd_ctr_nxt = upd_ctr + ctr_width'(1);
      end
    end else if (upd_ctr != '0) begin
      upd_ctr_nxt = upd_ctr - ctr_width'(1);
    end
  end

  always_comb begin
    state_nxt    = state_q;
    init_idx_nxt = init_idx_q;
    hist_nxt     = hist_q;
    wr_vld       = 1'b0;
    wr_idx       = upd_idx;
    wr_dat       = upd_ctr_nxt;
    case (state_q)
      BP_INIT: begin
        wr_vld       = 1'b1;
        wr_idx       = init_idx_q;
        wr_dat       = weak_not_taken();
        init_idx_nxt = init_idx_q + index_bits'(1);
        if (init_idx_q == last_idx) begin
          state_nxt = BP_RUN;
        end
      end
      BP_RUN: begin
        wr_vld = bp.update_valid;
        // A WB mispredict flushes the younger ID branch, so its shift is dropped.
        if (bp.update_valid && bp.mispredict_wb) begin
          hist_nxt = shift_in(bp.hist_wb, bp.taken_wb);
        end else if (bp.predict_valid) begin
          hist_nxt = shift_in(hist_q, pred_taken);
        end
      end
      default: begin
        state_nxt = BP_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
      hist_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      init_idx_q <= init_idx_nxt;
      hist_q     <= hist_nxt;
    end
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised next-generation global-history (gshare) direction predictor for the LC-3b pipeline.
- Predicts in ID and trains from WB.
- Adds configurable counter width and speculative global history, with restore on mispredict.
- Runs a reset-time table-initialisation sweep so every counter starts weakly-not-taken.

Parameters:
- hist_width, 4: global history bits; must satisfy 1 <= hist_width <= index_bits.
- index_bits, 5: log2 of counter-table depth (2^index_bits entries).
- ctr_width, 2: saturating counter width; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- predict_valid  input  1  ID stage holds a conditional branch (op_br) this cycle.
- PC_id  input  16  PC of the ID-stage instruction.
- predict_taken  output  1  prediction for PC_id.
- branch_hist_id  output  hist_width  history used for this prediction; travels down the pipe.
- ready  output  1  high once table initialisation is complete.
- update_valid  input  1  a conditional branch resolved in WB this cycle.
- PC_wb  input  16  PC of the resolved branch.
- hist_wb  input  hist_width  branch_hist_id carried with that branch.
- taken_wb  input  1  actual outcome.
- mispredict_wb  input  1  the prediction for this branch was wrong.

Behaviour:
- Indexing: base = PC[index_bits:1]; PC bit 0 is always 0.
  - idx = {base[index_bits-1:index_bits-hist_width] XOR hist, base[index_bits-hist_width-1:0]}.
  - Read index uses PC_id and the current history register.
  - Update index uses PC_wb and hist_wb.
- Prediction is combinational, same cycle: predict_taken = MSB of the indexed counter AND ready.
- branch_hist_id = current history register value, before any shift.
- Counter update on update_valid & ready:
  - taken_wb=1: counter+1, saturating at 2^ctr_width-1.
  - taken_wb=0: counter-1, saturating at 0.
  - The new value is written at the clock edge.
- Read-during-write to the same index returns the old value; the new value is visible the next cycle.
- Speculative history: on predict_valid & ready & !(update_valid & mispredict_wb), hist <= {hist[hist_width-2:0], predict_taken}. New bit enters at the LSB; the oldest bit is dropped.
- Recovery: on update_valid & mispredict_wb & ready, hist <= {hist_wb[hist_width-2:0], taken_wb}.
  - Recovery has priority over a simultaneous speculative shift; the ID branch is younger and is flushed.
- Correctly predicted updates do not modify history.
- hist_width=1 corner: shift and restore reduce to hist <= new bit.
- FSM states: INIT, RUN.
  - reset asserted (low): state=INIT, init_idx=0, hist=0, ready=0, predict_taken=0. Applies at any time, including mid-operation; the table is re-initialised.
  - INIT: each cycle write weakly-not-taken (2^(ctr_width-1)-1) to entry init_idx, then init_idx+1.
  - INIT ignores predict_valid and update_valid: no history shift, no training.
  - INIT -> RUN after writing the last entry (init_idx = 2^index_bits-1), i.e. 2^index_bits cycles after reset release. ready rises the following cycle.
  - RUN: remains in RUN until reset.
- Outputs never X after reset: the table is fully written before ready=1.

Decomposition:
- lc3b_types package: lc3b_word and op_br, already present.
- Add to lc3b_types: a bp_state_t enum {BP_INIT, BP_RUN}.
- Weakly-not-taken init value is a function of ctr_width inside the module, not a package constant.
- One sub-module: bp_counter_table.
  - Parametrised width/depth register array.
  - One async read port for prediction, one async read port for update.
  - One write port, muxed between init sweep and training.

Test Plan:
- Reset sequence (defaults): release reset -> ready=0 for exactly 32 cycles, then 1. Every entry reads 2'b01 and predict_taken=0 for all PC_id.
- Saturation up: 3 taken updates at PC_wb=16'h0010, hist_wb=0 -> counter 01->10->11->11. Prediction for PC_id=16'h0010 with hist=0 becomes 1 after the first update.
- Saturation down, ctr_width=3: 5 not-taken updates from init value 3'b011 -> 010, 001, 000, 000, 000.
- Speculative shift and restore: hist=4'b0000, predict_valid with predict_taken=1 -> hist=0001. Same cycle as the next predict, update_valid with mispredict_wb=1, hist_wb=4'b1010, taken_wb=0 -> hist=0100; the speculative shift is dropped.
- Aliasing via XOR: PC_id=16'h0002 with hist=0001 indexes entry 00011. An update at PC_wb=16'h0006 with hist_wb=0000 trains the same entry, and the prediction changes accordingly.
- Mid-run reset: assert reset during training -> ready=0 and hist=0 immediately. After release, the full 32-cycle sweep repeats and previously trained entries read 01 again.
